// File: rtl/mips_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
// Loader state encoding, header field position and instruction word width.
package mips_pkg;

  localparam int INSN_WIDTH    = 32;
  localparam int HDR_COUNT_LSB = 0;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    CHECK,
    RUN,
    ERR
  } loader_state_t;

  // States in which the loader consumes stream beats
  function automatic logic is_streaming(input loader_state_t s);
    return (s == HEADER) || (s == PAYLOAD) || (s == CHECK);
  endfunction

endpackage

// File: rtl/loader_checksum.sv
// Running 32-bit modular sum of the payload words, with a compare
// against the trailer word supplied by the stream.
module loader_checksum
  import mips_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  add,
  input  logic [INSN_WIDTH-1:0] data,
  input  logic [INSN_WIDTH-1:0] cmp_data,
  output logic                  match
);

  logic [INSN_WIDTH-1:0] sum_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sum_reg <= '0;
    end else if (add) begin
      sum_reg <= sum_reg + data;
    end
  end

  assign match = (sum_reg == cmp_data);

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed program image into instruction memory and holds
// the core in reset until it is written. Optional trailer check: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  s_valid,
  input  logic [INSN_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  imem_we,
  output logic [31:0]           imem_addr,
  output logic [INSN_WIDTH-1:0] imem_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int CW  = ADDR_WIDTH + 1;
  localparam int PAD = 32 - ADDR_WIDTH - 2;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);

  loader_state_t state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic [CW-1:0] k_reg, k_next;
  logic [CW-1:0] hdr_count;
  logic          accept;
  logic          last_beat;

  logic                  s_ready_reg, imem_we_reg, cpu_reset_reg;
  logic                  busy_reg, done_reg, error_reg;
  logic [31:0]           imem_addr_reg;
  logic [INSN_WIDTH-1:0] imem_wdata_reg;

  assign accept    = s_valid && s_ready_reg;
  assign hdr_count = s_data[HDR_COUNT_LSB +: CW];
  assign last_beat = (k_reg == count_reg - CW'(1));

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic sum_match;

  loader_checksum u_checksum (
    .clk      (clk),
    .reset    (reset),
    .clear    (state_reg == HEADER && accept),
    .add      (state_reg == PAYLOAD && accept),
    .data     (s_data),
    .cmp_data (s_data),
    .match    (sum_match)
  );
`endif

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    k_next     = k_reg;
    case (state_reg)
      IDLE: begin
        if (start) state_next = HEADER;
      end
      HEADER: begin
        if (accept) begin
          if (hdr_count == '0 || hdr_count > MAX_CNT) begin
            state_next = ERR;
          end else begin
            count_next = hdr_count;
            k_next     = '0;
            state_next = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (accept) begin
          k_next = k_reg + CW'(1);
          if (last_beat) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_next = CHECK;
`else
            state_next = RUN;
`endif
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (accept) state_next = sum_match ? RUN : ERR;
      end
`endif
      RUN, ERR: begin
        if (start) state_next = HEADER;
      end
      default: state_next = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it;
  // cpu_reset drops only after a full cycle in RUN, behind the last write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      k_reg          <= '0;
      s_ready_reg    <= 1'b0;
      imem_we_reg    <= 1'b0;
      imem_addr_reg  <= '0;
      imem_wdata_reg <= '0;
      cpu_reset_reg  <= 1'b1;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      k_reg         <= k_next;
      s_ready_reg   <= is_streaming(state_next);
      busy_reg      <= is_streaming(state_next);
      done_reg      <= (state_next == RUN);
      error_reg     <= (state_next == ERR);
      cpu_reset_reg <= !(state_reg == RUN && state_next == RUN);
      imem_we_reg   <= (state_reg == PAYLOAD) && accept;
      if (state_reg == PAYLOAD && accept) begin
        imem_addr_reg  <= {{PAD{1'b0}}, k_reg[ADDR_WIDTH-1:0], 2'b00};
        imem_wdata_reg <= s_data;
      end
    end
  end

  assign s_ready    = s_ready_reg;
  assign imem_we    = imem_we_reg;
  assign imem_addr  = imem_addr_reg;
  assign imem_wdata = imem_wdata_reg;
  assign cpu_reset  = cpu_reset_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign error      = error_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed cases plus random images,
// with a write scoreboard drained by a monitor. Define IMEM_LOADER_CHECKSUM_EN for trailer cases.
module tb_imem_loader;

  localparam int AW  = 8;
  localparam int MAX = 256;

  typedef logic [31:0] word_q_t[$];

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready, imem_we, cpu_reset, busy, done, error;
  logic [31:0] imem_addr, imem_wdata;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  imem_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MAX)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h want=0x%08h at %0t", name, got, exp, $time);
    end else begin
      $display("ok   %s = 0x%08h", name, got);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    sync();
    start = 1'b0;
    @(negedge clk);
    chk("start_busy", busy, 1);
    chk("start_ready", s_ready, 1);
    chk("start_cpu_reset", cpu_reset, 1);
    chk("start_done", done, 0);
    sync();
  endtask

  task automatic stall(input int gap);
    s_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      chk("ready_in_gap", s_ready, 1);
      sync();
    end
  endtask

  task automatic beat(input logic [31:0] d);
    logic accepted;
    accepted = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    if (!accepted) chk("ready_timeout", 0, 1);
    sync();
    s_valid = 1'b0;
  endtask

  // Model: count = low AW+1 header bits; legal iff 1..MAX; writes are word i at 4*i;
  // with the trailer enabled the load succeeds iff trailer == sum of words mod 2^32.
  task automatic run_load(input logic [31:0] hdr, input word_q_t words, input int gap,
                          input logic bad_sum);
    int          n;
    logic        ok;
    logic [31:0] sum;
    n = int'(hdr & ((32'd1 << (AW + 1)) - 1));
    do_start();
    beat(hdr);
    if (n == 0 || n > MAX) begin
      @(negedge clk);
      chk("hdr_error", error, 1);
      chk("hdr_cpu_reset", cpu_reset, 1);
      chk("hdr_busy", busy, 0);
      sync();
      return;
    end
    sum = '0;
    foreach (words[i]) begin
      sum += words[i];
      exp_q.push_back({32'(i * 4), words[i]});
      if (i != 0) stall(gap);
      beat(words[i]);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    stall(gap);
    beat(bad_sum ? sum + 32'd1 : sum);
    ok = !bad_sum;
`else
    ok = 1'b1;
`endif
    @(negedge clk);
    if (ok) begin
      chk("end_done", done, 1);
      chk("end_cpu_reset_hold", cpu_reset, 1);
      chk("end_busy", busy, 0);
      @(negedge clk);
      chk("end_cpu_reset_fall", cpu_reset, 0);
    end else begin
      chk("sum_error", error, 1);
      chk("sum_cpu_reset", cpu_reset, 1);
      chk("sum_done", done, 0);
    end
    sync();
  endtask

  word_q_t img_a, img_b, img_r;

  initial begin
    img_a = '{32'h20080005, 32'h20090007, 32'h01095020};
    img_b = '{32'h1, 32'h2, 32'h3};

    fork
      forever begin
        @(negedge clk);
        if (imem_we) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_we", imem_addr, 32'hFFFFFFFF);
          end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            chk("we_addr", imem_addr, e[63:32]);
            chk("we_data", imem_wdata, e[31:0]);
          end
        end
      end
    join_none

    repeat (3) sync();
    @(negedge clk);
    chk("rst_ready", s_ready, 0);
    chk("rst_we", imem_we, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    sync();
    reset = 1'b0;
    sync();

    run_load(32'd3, img_a, 0, 1'b0);
    run_load(32'd3, img_a, 2, 1'b0);
    run_load(32'd0, img_a, 0, 1'b0);
    run_load(32'd257, img_a, 0, 1'b0);
    run_load(32'd3, img_b, 0, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    run_load(32'd3, img_b, 1, 1'b1);
`endif

    // Reset after two of four payload words
    do_start();
    beat(32'd4);
    exp_q.push_back({32'h0, 32'hAAAA0000});
    beat(32'hAAAA0000);
    exp_q.push_back({32'h4, 32'hAAAA0001});
    beat(32'hAAAA0001);
    reset = 1'b1;
    sync();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", s_ready, 0);
    chk("mid_rst_we", imem_we, 0);
    chk("mid_rst_addr", imem_addr, 0);
    chk("mid_rst_wdata", imem_wdata, 0);
    chk("mid_rst_cpu_reset", cpu_reset, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_error", error, 0);
    sync();
    run_load(32'd4, '{32'hB0, 32'hB1, 32'hB2, 32'hB3}, 0, 1'b0);

    // Random images, bad headers with junk upper bits, random stalls
    for (int t = 0; t < 12; t++) begin
      int          n;
      logic [31:0] hdr;
      img_r = {};
      if ($urandom_range(0, 4) == 0) begin
        n = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(MAX + 1, 511));
      end else begin
        n = int'($urandom_range(1, 8));
        for (int i = 0; i < n; i++) img_r.push_back($urandom);
      end
      hdr = ($urandom & ~32'h1FF) | 32'(n);
      run_load(hdr, img_r, int'($urandom_range(0, 2)), $urandom_range(0, 3) == 0);
    end

    repeat (3) sync();
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader directly upstream of the instruction memory. It accepts a word stream on a valid/ready interface and writes it into instruction memory starting at byte address 0. It holds the processor in reset until the image is fully written, then releases it, so the PC's first fetch after release sees the loaded program.

## Interface
- `ADDR_WIDTH`, default 8: word-address width of instruction memory; capacity is 2^ADDR_WIDTH words.
- `MAX_WORDS`, default 256: largest accepted image, in words; must be ≤ 2^ADDR_WIDTH.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse that begins a load.
- `s_valid`  in  1  stream word valid.
- `s_data`  in  32  stream word.
- `s_ready`  out  1  loader accepts `s_data` this cycle.
- `imem_we`  out  1  instruction-memory write strobe.
- `imem_addr`  out  32  byte address, always word-aligned (bits [1:0] = 0).
- `imem_wdata`  out  32  instruction word to write.
- `cpu_reset`  out  1  reset to the PC, register file and the rest of the core.
- `busy`  out  1  high while a load is in progress.
- `done`  out  1  image loaded; core running.
- `error`  out  1  load aborted.

## Operation
- The FSM has these states: IDLE, HEADER, PAYLOAD, CHECK, RUN and ERR.
- **IDLE**: `start` moves the FSM to HEADER.
- **HEADER**: one accepted beat is the word count N, taken from `s_data[ADDR_WIDTH:0]`; upper bits are ignored.
  - If N = 0 or N > MAX_WORDS, go to ERR.
  - Otherwise clear the word counter k and go to PAYLOAD.
- **PAYLOAD**: each accepted beat writes word k to byte address k·4, then k increments.
  - After beat N−1, go to CHECK if the checksum is enabled, otherwise go to RUN.
- **CHECK**: one accepted beat is compared with the running checksum.
  - Match goes to RUN. Mismatch goes to ERR.
- **RUN**: the core executes.
  - `start` returns the FSM to HEADER and reasserts `cpu_reset`, which reloads the image.
- **ERR**: `start` returns the FSM to HEADER. No other exit except `reset`.
- `s_ready` is 1 in HEADER, PAYLOAD and CHECK, and 0 in all other states. It is driven from registered state only.
- A beat is accepted when `s_valid && s_ready`. Words with `s_valid` low are not consumed, and arbitrary stall gaps are allowed.
- `start` in HEADER, PAYLOAD or CHECK is ignored.
- `cpu_reset` is 1 in every state except RUN.
- `busy` is 1 in HEADER, PAYLOAD and CHECK.
- `done` is 1 in RUN.
- `error` is 1 in ERR.
- Memory addresses wrap modulo 2^ADDR_WIDTH words. Because N ≤ MAX_WORDS, no wrap can occur in a legal load.

## Timing
- All outputs are registered. Reset values:
  - `s_ready` = 0, `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0
  - `cpu_reset` = 1, `busy` = 0, `done` = 0, `error` = 0
  - state = IDLE.
- `start` in cycle t: `busy` = 1 and `s_ready` = 1 in cycle t+1.
- Payload beat accepted in cycle t: `imem_we` = 1 in cycle t+1, with `imem_addr` = k·4 and `imem_wdata` equal to that beat. `imem_we` is a single-cycle pulse per word.
- Throughput is one word per cycle.
- Final accepted beat (last payload word, or checksum when enabled) in cycle t:
  - state = RUN and `done` = 1 in t+1.
  - `cpu_reset` falls in t+2, one cycle after the last `imem_we` pulse.
- `reset` in any state returns to IDLE next cycle with all reset values. A partially written image is left in memory, and the core stays in reset.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - CHECK state exists.
  - The checksum is the 32-bit sum, mod 2^32, of all N payload words.
  - The trailing word must equal it, otherwise the FSM goes to ERR with `cpu_reset` held high.
- Not defined:
  - CHECK is removed, and the last payload beat goes straight to RUN.
  - The stream carries no trailer word.

## Structure
- Shared package `mips_pkg`:
  - loader state enum;
  - header count field position;
  - instruction word width (32).
- Sub-module `loader_checksum`: 32-bit accumulator with clear/add/compare. It is instantiated only under `IMEM_LOADER_CHECKSUM_EN`.

## Test plan
- Basic load, no checksum:
  - `start`, then header 3, then words 0x20080005, 0x20090007, 0x01095020 with `s_valid` held high.
  - Required: `imem_we` on three consecutive cycles, at addresses 0x0, 0x4, 0x8 with matching data.
  - Required: `done` = 1 the cycle after the last beat; `cpu_reset` falls one cycle later.
- Stalls:
  - Same image with `s_valid` low for 2 cycles between every word.
  - Required: identical writes in the same order; `s_ready` stays 1 throughout; no extra `imem_we` pulses.
- Bad header:
  - Header 0, and separately header MAX_WORDS+1 = 257.
  - Required: `error` = 1, `cpu_reset` = 1, no `imem_we`.
  - Required: a subsequent `start` returns `busy` = 1.
- Checksum (with `IMEM_LOADER_CHECKSUM_EN`):
  - Image 1, 2, 3 with trailer 6: `done` = 1.
  - Same image with trailer 7: `error` = 1 and `cpu_reset` = 1.
- Reset mid-load:
  - Assert `reset` after 2 of 4 payload words.
  - Required: next cycle all outputs are at reset values and state is IDLE.
  - Required: a fresh `start` plus full image completes normally.
- Reload from RUN:
  - `start` in RUN.
  - Required: `cpu_reset` = 1 and `done` = 0 next cycle; the new image overwrites address 0 onward.
